// File: rtl/ptp_up_arbiter_if.sv
// ---------------------------------------------------------------------------
// ptp_up_arbiter_if
// Master-side register request port for ptp_up_arbiter. One instance per
// master (host CPU, servo/timestamp poller).
//
// Signals:
//   req    master -> arbiter  level request, held until ack
//   wr     master -> arbiter  1 = write, 0 = read; stable while req
//   addr   master -> arbiter  register address
//   wdata  master -> arbiter  write data
//   lock   master -> arbiter  keep the bus for the next transaction
//                             (only honoured with PTP_ARB_LOCK_EN)
//   gnt    arbiter -> master  master owns the bus
//   ack    arbiter -> master  one-cycle completion pulse
//   rdata  arbiter -> master  read data, valid with ack
//
// Modports: master (requesting side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface ptp_up_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, addr, wdata, lock,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, wr, addr, wdata, lock,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/ptp_up_arbiter.sv
// ---------------------------------------------------------------------------
// ptp_up_arbiter
// Two-master round-robin arbiter and sequencer in front of the ha1588 core
// register bus. Level-held requests from m0 (host CPU) and m1 (on-chip
// servo/timestamp poller) are turned into single-cycle wr/rd strobes; reads
// wait a fixed RD_LAT cycles and return data with a one-cycle ack.
//
// Parameters:
//   RD_LAT  cycles from the rd_out strobe cycle to the data_in-valid cycle
//           (legal range 1..15)
//   ADDR_W  register address width
//   DATA_W  register data width
//
// Ports:
//   clk       single clock, same as core clock
//   rst       synchronous active-high reset
//   m0, m1    ptp_up_arbiter_if.slave request ports
//   wr_out    one-cycle write strobe to the core
//   rd_out    one-cycle read strobe to the core
//   addr_out  core address (holds last transaction while idle)
//   data_out  core write data (holds last transaction while idle)
//   data_in   core read data
//
// Optional feature macro: PTP_ARB_LOCK_EN
//   When defined, a winner with lock high in its DONE cycle keeps the bus:
//   the priority pointer is not flipped and only that master is arbitrated
//   until it completes a transaction with lock low or drops req in IDLE.
//   When undefined, the lock inputs are ignored (pure round-robin).
// ---------------------------------------------------------------------------
module ptp_up_arbiter #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  ptp_up_arbiter_if.slave   m0,
  ptp_up_arbiter_if.slave   m1,
  output logic              wr_out,
  output logic              rd_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // WAIT starts one cycle after the strobe, so the counter reaches zero in
  // the data_in-valid cycle when loaded with RD_LAT-1.
  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

  state_t            state;
  state_t            state_next;

  logic              winner;        // 0 = m0, 1 = m1
  logic              winner_next;
  logic              txn_wr;
  logic              txn_wr_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              prio;          // preferred master on a tie
  logic              prio_next;

  logic              gnt0;
  logic              gnt0_next;
  logic              gnt1;
  logic              gnt1_next;
  logic              ack0;
  logic              ack0_next;
  logic              ack1;
  logic              ack1_next;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata0_next;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata1_next;

  logic              wr_out_next;
  logic              rd_out_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;

  logic              elig0;
  logic              elig1;
  logic              win_any;
  logic              win_sel;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef PTP_ARB_LOCK_EN
  logic              lock_flag;
  logic              lock_flag_next;
  logic              owner_req;
  logic              owner_lock;
  logic              lock_active;

  // The lock owner is always the last winner. Dropping its req in IDLE
  // releases the lock in that same cycle so the other master can win.
  assign owner_req   = winner ? m1.req  : m0.req;
  assign owner_lock  = winner ? m1.lock : m0.lock;
  assign lock_active = lock_flag && owner_req;
  assign elig0       = m0.req && !(lock_active && winner);
  assign elig1       = m1.req && !(lock_active && !winner);
`else
  logic              unused_lock;

  assign unused_lock = m0.lock ^ m1.lock;
  assign elig0       = m0.req;
  assign elig1       = m1.req;
`endif

  // On a tie the priority pointer decides; otherwise the lone requester.
  assign win_any   = elig0 || elig1;
  assign win_sel   = (elig0 && elig1) ? prio : elig1;
  assign sel_wr    = win_sel ? m1.wr    : m0.wr;
  assign sel_addr  = win_sel ? m1.addr  : m0.addr;
  assign sel_wdata = win_sel ? m1.wdata : m0.wdata;

  assign m0.gnt   = gnt0;
  assign m0.ack   = ack0;
  assign m0.rdata = rdata0;
  assign m1.gnt   = gnt1;
  assign m1.ack   = ack1;
  assign m1.rdata = rdata1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (txn_wr) begin
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output and datapath next values; everything is registered below.
  always_comb begin
    winner_next = winner;
    txn_wr_next = txn_wr;
    cnt_next    = cnt;
    prio_next   = prio;
    gnt0_next   = gnt0;
    gnt1_next   = gnt1;
    ack0_next   = 1'b0;
    ack1_next   = 1'b0;
    rdata0_next = rdata0;
    rdata1_next = rdata1;
    wr_out_next = 1'b0;
    rd_out_next = 1'b0;
    addr_next   = addr_out;
    data_next   = data_out;
`ifdef PTP_ARB_LOCK_EN
    lock_flag_next = lock_flag;
`endif
    case (state)
      IDLE: begin
        if (win_any) begin
          winner_next = win_sel;
          txn_wr_next = sel_wr;
          addr_next   = sel_addr;
          data_next   = sel_wdata;
          gnt0_next   = !win_sel;
          gnt1_next   = win_sel;
          // Strobe is registered so it appears in the ISSUE cycle.
          wr_out_next = sel_wr;
          rd_out_next = !sel_wr;
        end else begin
          gnt0_next = 1'b0;
          gnt1_next = 1'b0;
        end
`ifdef PTP_ARB_LOCK_EN
        if (lock_flag && !owner_req) begin
          lock_flag_next = 1'b0;
        end else begin
          lock_flag_next = lock_flag;
        end
`endif
      end
      ISSUE: begin
        if (txn_wr) begin
          ack0_next = !winner;
          ack1_next = winner;
        end else begin
          cnt_next = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          ack0_next = !winner;
          ack1_next = winner;
          if (winner) begin
            rdata1_next = data_in;
          end else begin
            rdata0_next = data_in;
          end
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE: begin
        gnt0_next = 1'b0;
        gnt1_next = 1'b0;
`ifdef PTP_ARB_LOCK_EN
        if (owner_lock) begin
          lock_flag_next = 1'b1;
          prio_next      = prio;
        end else begin
          lock_flag_next = 1'b0;
          prio_next      = !winner;
        end
`else
        prio_next = !winner;
`endif
      end
      default: begin
        gnt0_next = 1'b0;
        gnt1_next = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      winner   <= 1'b0;
      txn_wr   <= 1'b0;
      cnt      <= 4'd0;
      prio     <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      wr_out   <= 1'b0;
      rd_out   <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
`ifdef PTP_ARB_LOCK_EN
      lock_flag <= 1'b0;
`endif
    end else begin
      winner   <= winner_next;
      txn_wr   <= txn_wr_next;
      cnt      <= cnt_next;
      prio     <= prio_next;
      gnt0     <= gnt0_next;
      gnt1     <= gnt1_next;
      ack0     <= ack0_next;
      ack1     <= ack1_next;
      rdata0   <= rdata0_next;
      rdata1   <= rdata1_next;
      wr_out   <= wr_out_next;
      rd_out   <= rd_out_next;
      addr_out <= addr_next;
      data_out <= data_next;
`ifdef PTP_ARB_LOCK_EN
      lock_flag <= lock_flag_next;
`endif
    end
  end

endmodule

// File: tb/tb_ptp_up_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ptp_up_arbiter
// Table-driven bench for ptp_up_arbiter. Instance "a" (RD_LAT = 2) runs a
// cycle-by-cycle vector table; instance "b" (RD_LAT = 3) runs a hand-written
// reset-during-read sequence. Each table row lists the inputs held during a
// cycle and the outputs expected in that same cycle.
// ---------------------------------------------------------------------------
module tb_ptp_up_arbiter;

  logic clk;
  logic rst_a;
  logic rst_b;

  logic        wr_a, rd_a, wr_b, rd_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b, din_a, din_b;

  ptp_up_arbiter_if #(.ADDR_W(8), .DATA_W(32)) a_m0 ();
  ptp_up_arbiter_if #(.ADDR_W(8), .DATA_W(32)) a_m1 ();
  ptp_up_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b_m0 ();
  ptp_up_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b_m1 ();

  ptp_up_arbiter #(.RD_LAT(2), .ADDR_W(8), .DATA_W(32)) u_dut_a (
    .clk(clk), .rst(rst_a), .m0(a_m0), .m1(a_m1),
    .wr_out(wr_a), .rd_out(rd_a), .addr_out(addr_a), .data_out(data_a),
    .data_in(din_a)
  );

  ptp_up_arbiter #(.RD_LAT(3), .ADDR_W(8), .DATA_W(32)) u_dut_b (
    .clk(clk), .rst(rst_b), .m0(b_m0), .m1(b_m1),
    .wr_out(wr_b), .rd_out(rd_b), .addr_out(addr_b), .data_out(data_b),
    .data_in(din_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        r0, w0, l0;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic        r1, w1, l1;
    logic [7:0]  a1;
    logic [31:0] d1;
    logic [31:0] din;
    logic [5:0]  flg;   // {m0_gnt, m0_ack, m1_gnt, m1_ack, wr_out, rd_out}
    logic [7:0]  ao;
    logic [31:0] dout;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;
  int   row      = 0;
  logic prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic add(
    input logic rst,
    input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0, input logic l0,
    input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1, input logic l1,
    input logic [31:0] din, input logic [5:0] flg, input logic [7:0] ao, input logic [31:0] dout,
    input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = rst;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
    v.din = din; v.flg = flg; v.ao = ao; v.dout = dout; v.rd0 = rd0; v.rd1 = rd1;
    tbl.push_back(v);
  endtask

  task automatic build();
    // m0 write 0x10 <= 0xDEADBEEF (T = row 1)
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h00, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b1,1'b1,8'h10,32'hDEADBEEF,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h00, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b1,1'b1,8'h10,32'hDEADBEEF,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b100010, 8'h10, 32'hDEADBEEF, 32'h0, 32'h0);
    add(1'b0, 1'b1,1'b1,8'h10,32'hDEADBEEF,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b110000, 8'h10, 32'hDEADBEEF, 32'h0, 32'h0);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h10, 32'hDEADBEEF, 32'h0, 32'h0);
    // m1 read 0x24 (T = row 5), data valid at T+3; m0 pulses req in row 7
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h24,32'h0,1'b0, 32'h0, 6'b000000, 8'h10, 32'hDEADBEEF, 32'h0, 32'h0);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h24,32'h0,1'b0, 32'h0, 6'b001001, 8'h24, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b1,1'b1,8'h55,32'h0BADF00D,1'b0, 1'b1,1'b0,8'h24,32'h0,1'b0, 32'hFFFF0000, 6'b001000, 8'h24, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h24,32'h0,1'b0, 32'h12345678, 6'b001000, 8'h24, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h24,32'h0,1'b0, 32'h0, 6'b001100, 8'h24, 32'h0, 32'h0, 32'h12345678);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h24, 32'h0, 32'h0, 32'h12345678);
    // reset, then both masters request 4 writes each
    add(1'b1, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h24, 32'h0, 32'h0, 32'h12345678);
    for (int j = 0; j < 8; j++) begin
      logic        m;
      logic        r0;
      logic [7:0]  pao;
      logic [31:0] pdo;
      logic [7:0]  cao;
      logic [31:0] cdo;
      m   = (j % 2) == 1;
      r0  = (j < 7);
      cao = m ? 8'h41 : 8'h40;
      cdo = m ? 32'h5B5B5B5B : 32'hA0A0A0A0;
      pao = (j == 0) ? 8'h00 : (m ? 8'h40 : 8'h41);
      pdo = (j == 0) ? 32'h0 : (m ? 32'hA0A0A0A0 : 32'h5B5B5B5B);
      add(1'b0, r0,1'b1,8'h40,32'hA0A0A0A0,1'b0, 1'b1,1'b1,8'h41,32'h5B5B5B5B,1'b0, 32'h0,
          6'b000000, pao, pdo, 32'h0, 32'h0);
      add(1'b0, r0,1'b1,8'h40,32'hA0A0A0A0,1'b0, 1'b1,1'b1,8'h41,32'h5B5B5B5B,1'b0, 32'h0,
          m ? 6'b001010 : 6'b100010, cao, cdo, 32'h0, 32'h0);
      add(1'b0, r0,1'b1,8'h40,32'hA0A0A0A0,1'b0, 1'b1,1'b1,8'h41,32'h5B5B5B5B,1'b0, 32'h0,
          m ? 6'b001100 : 6'b110000, cao, cdo, 32'h0, 32'h0);
    end
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h41, 32'h5B5B5B5B, 32'h0, 32'h0);
    // m1 reads 0x30 with lock high, then 0x34 with lock low; m0 requests from row 38
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h30,32'h0,1'b1, 32'h0, 6'b000000, 8'h41, 32'h5B5B5B5B, 32'h0, 32'h0);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h30,32'h0,1'b1, 32'h0, 6'b001001, 8'h30, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h30,32'h0,1'b1, 32'hFFFF0000, 6'b001000, 8'h30, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h30,32'h0,1'b1, 32'h11111111, 6'b001000, 8'h30, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h30,32'h0,1'b1, 32'h0, 6'b001100, 8'h30, 32'h0, 32'h0, 32'h11111111);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h0, 6'b000000, 8'h30, 32'h0, 32'h0, 32'h11111111);
`ifdef PTP_ARB_LOCK_EN
    // locked: m1's second read follows immediately, then m0
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h0, 6'b001001, 8'h34, 32'h0, 32'h0, 32'h11111111);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'hFFFF0000, 6'b001000, 8'h34, 32'h0, 32'h0, 32'h11111111);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h22222222, 6'b001000, 8'h34, 32'h0, 32'h0, 32'h11111111);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h0, 6'b001100, 8'h34, 32'h0, 32'h0, 32'h22222222);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h34, 32'h0, 32'h0, 32'h22222222);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b100010, 8'h50, 32'h1, 32'h0, 32'h22222222);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b110000, 8'h50, 32'h1, 32'h0, 32'h22222222);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h50, 32'h1, 32'h0, 32'h22222222);
`else
    // lock ignored: m0 wins after m1's first read, then m1's second read
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h0, 6'b100010, 8'h50, 32'h1, 32'h0, 32'h11111111);
    add(1'b0, 1'b1,1'b1,8'h50,32'h1,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h0, 6'b110000, 8'h50, 32'h1, 32'h0, 32'h11111111);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h0, 6'b000000, 8'h50, 32'h1, 32'h0, 32'h11111111);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h0, 6'b001001, 8'h34, 32'h0, 32'h0, 32'h11111111);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'hFFFF0000, 6'b001000, 8'h34, 32'h0, 32'h0, 32'h11111111);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h22222222, 6'b001000, 8'h34, 32'h0, 32'h0, 32'h11111111);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b1,1'b0,8'h34,32'h0,1'b0, 32'h0, 6'b001100, 8'h34, 32'h0, 32'h0, 32'h22222222);
    add(1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 1'b0,1'b0,8'h00,32'h0,1'b0, 32'h0, 6'b000000, 8'h34, 32'h0, 32'h0, 32'h22222222);
`endif
  endtask

  task automatic apply(input vec_t v);
    rst_a       = v.rst;
    a_m0.req    = v.r0; a_m0.wr = v.w0; a_m0.addr = v.a0; a_m0.wdata = v.d0; a_m0.lock = v.l0;
    a_m1.req    = v.r1; a_m1.wr = v.w1; a_m1.addr = v.a1; a_m1.wdata = v.d1; a_m1.lock = v.l1;
    din_a       = v.din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t cur;
    rst_a = 1'b1;
    rst_b = 1'b1;
    din_a = 32'h0;
    din_b = 32'h0;
    a_m0.req = 1'b0; a_m0.wr = 1'b0; a_m0.addr = 8'h00; a_m0.wdata = 32'h0; a_m0.lock = 1'b0;
    a_m1.req = 1'b0; a_m1.wr = 1'b0; a_m1.addr = 8'h00; a_m1.wdata = 32'h0; a_m1.lock = 1'b0;
    b_m0.req = 1'b0; b_m0.wr = 1'b0; b_m0.addr = 8'h00; b_m0.wdata = 32'h0; b_m0.lock = 1'b0;
    b_m1.req = 1'b0; b_m1.wr = 1'b0; b_m1.addr = 8'h00; b_m1.wdata = 32'h0; b_m1.lock = 1'b0;
    build();
    repeat (3) @(posedge clk);

    // Instance a: vector table
    for (int k = 0; k < tbl.size(); k++) begin
      tick();
      cur = tbl[k];
      row = k;
      apply(cur);
      chk("flags", {26'd0, a_m0.gnt, a_m0.ack, a_m1.gnt, a_m1.ack, wr_a, rd_a}, {26'd0, cur.flg});
      chk("addr_out", {24'd0, addr_a}, {24'd0, cur.ao});
      chk("data_out", data_a, cur.dout);
      chk("m0_rdata", a_m0.rdata, cur.rd0);
      chk("m1_rdata", a_m1.rdata, cur.rd1);
      chk("strobe_excl", {31'd0, wr_a & rd_a}, 32'd0);
      chk("strobe_gap", {31'd0, prev_strobe & (wr_a | rd_a)}, 32'd0);
      prev_strobe = wr_a | rd_a;
    end

    // Instance b (RD_LAT = 3): reset during a read's WAIT
    row = 1000;
    tick();
    rst_b = 1'b0;
    b_m0.req = 1'b1; b_m0.wr = 1'b1; b_m0.addr = 8'h01; b_m0.wdata = 32'h11;
    chk("b_reset_flags", {26'd0, b_m0.gnt, b_m0.ack, b_m1.gnt, b_m1.ack, wr_b, rd_b}, 32'd0);
    chk("b_reset_addr", {24'd0, addr_b}, 32'd0);
    row = 1001; tick();
    chk("b_m0_issue", {29'd0, b_m0.gnt, wr_b, rd_b}, 32'd6);
    row = 1002; tick();
    chk("b_m0_ack", {30'd0, b_m0.ack, b_m0.gnt}, 32'd3);
    row = 1003; tick();
    b_m0.req = 1'b0;
    b_m1.req = 1'b1; b_m1.wr = 1'b0; b_m1.addr = 8'h66; b_m1.wdata = 32'h99;
    chk("b_m0_idle", {31'd0, b_m0.gnt}, 32'd0);
    row = 1004; tick();
    chk("b_m1_rd", {29'd0, b_m1.gnt, rd_b, wr_b}, 32'd6);
    chk("b_m1_addr", {24'd0, addr_b}, 32'h66);
    row = 1005; tick();
    rst_b = 1'b1;
    din_b = 32'hCAFEF00D;
    chk("b_m1_wait", {30'd0, b_m1.gnt, rd_b}, 32'd2);
    row = 1006; tick();
    rst_b = 1'b0;
    b_m1.req = 1'b0;
    chk("b_after_rst_flags", {26'd0, b_m0.gnt, b_m0.ack, b_m1.gnt, b_m1.ack, wr_b, rd_b}, 32'd0);
    chk("b_after_rst_addr", {24'd0, addr_b}, 32'd0);
    chk("b_after_rst_data", data_b, 32'd0);
    chk("b_after_rst_rdata", b_m1.rdata, 32'd0);
    row = 1007; tick();
    b_m0.req = 1'b1; b_m0.wr = 1'b1; b_m0.addr = 8'h70; b_m0.wdata = 32'h7;
    b_m1.req = 1'b1; b_m1.wr = 1'b1; b_m1.addr = 8'h71; b_m1.wdata = 32'h8;
    chk("b_no_ack_1", {31'd0, b_m1.ack}, 32'd0);
    row = 1008; tick();
    chk("b_prio_m0", {29'd0, b_m0.gnt, b_m1.gnt, wr_b}, 32'd5);
    chk("b_prio_addr", {24'd0, addr_b}, 32'h70);
    chk("b_no_ack_2", {31'd0, b_m1.ack}, 32'd0);
    row = 1009; tick();
    b_m0.req = 1'b0;
    b_m1.req = 1'b0;
    chk("b_final_ack", {30'd0, b_m0.ack, b_m1.ack}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ptp_up_arbiter.md
Name: ptp_up_arbiter

Overview:
- Two-master round-robin arbiter and sequencer for the ha1588 8-bit-address / 32-bit-data register bus (wr_in, rd_in, addr_in, data_in, data_out on the core).
- Lets the host CPU port (m0) and an on-chip servo/timestamp poller (m1) share the core's register interface.
- Converts level-held requests into single-cycle wr/rd strobes, waits a fixed read latency, and returns read data with a one-cycle ack.

Parameters:
- RD_LAT, 1: cycles from the rd_out strobe cycle to the data_in-valid cycle; legal range 1..15.
- ADDR_W, 8: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  input  1  single clock, same as core clk.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 transaction request; level, held until m0_ack.
- m0_wr  input  1  1 = write, 0 = read; stable while m0_req.
- m0_addr  input  ADDR_W  master 0 register address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_lock  input  1  bus lock request (used only with PTP_ARB_LOCK_EN).
- m0_gnt  output  1  master 0 owns the bus.
- m0_ack  output  1  one-cycle completion pulse.
- m0_rdata  output  DATA_W  read data; valid when m0_ack is high.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_ack, m1_rdata: same as m0_* for master 1.
- wr_out  output  1  one-cycle write strobe to the core.
- rd_out  output  1  one-cycle read strobe to the core.
- addr_out  output  ADDR_W  core address.
- data_out  output  DATA_W  core write data.
- data_in  input  DATA_W  core read data.

Behaviour:
- Reset values (synchronous): state = IDLE; all gnt, ack, wr_out, rd_out = 0; addr_out, data_out, rdata = 0; priority pointer = m0; wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE (cycle T):
  - No request: stay in IDLE.
  - One request: that master wins.
  - Both request: the master named by the priority pointer wins.
  - On a win: latch the winner's wr/addr/wdata into addr_out/data_out, set its gnt, go to ISSUE.
- ISSUE (T+1): exactly one of wr_out/rd_out is high for one cycle, matching the latched wr bit.
  - Write: go to DONE.
  - Read: load the counter with RD_LAT-1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter is 0 (cycle T+1+RD_LAT), register data_in into the winner's rdata and go to DONE.
- DONE: pulse the winner's ack for one cycle, flip the priority pointer to the other master, go to IDLE.
  - gnt is high from ISSUE through DONE inclusive and low in IDLE.
- Latency:
  - Write: ack in T+2.
  - Read: ack in T+2+RD_LAT.
  - Next arbitration in T+3 (write) or T+3+RD_LAT (read).
- Fields are sampled only in IDLE. Changes to req/wr/addr/wdata after the grant are ignored until ack.
- A master may drop req before being granted; the request is withdrawn with no bus activity.
- The non-granted master's ack stays 0. Its rdata holds its last value.
- addr_out and data_out hold the last transaction's values while IDLE.
- wr_out and rd_out are never high together, and never high in two consecutive cycles.
- A master holding req continuously alternates with the other requester; it never gets two grants in a row while the other requests.
- Reset asserted mid-transaction:
  - Next state is IDLE; no ack is issued.
  - Any pending strobe is suppressed in that cycle.
  - The priority pointer returns to m0.

Optional Feature:
- Macro: PTP_ARB_LOCK_EN.
- With the macro:
  - If the winner's lock input is high in its DONE cycle, the priority pointer is not flipped and a lock flag is set.
  - While the lock flag is set, IDLE considers only the locked master. The other master's req is ignored.
  - The lock flag clears when the locked master's lock is low in a DONE cycle, or when its req is low in IDLE; arbitration then proceeds normally.
  - Purpose: atomic multi-word reads of the seconds/nanoseconds time registers.
  - Reset clears the lock flag.
- Without the macro: m0_lock and m1_lock are ignored. Behaviour is pure round-robin.

Test Plan:
- m0 write only, addr 0x10, wdata 0xDEADBEEF → wr_out high one cycle at T+1 with addr_out 0x10 and data_out 0xDEADBEEF; m0_ack at T+2; m1_gnt stays 0.
- m1 read only, RD_LAT = 2, addr 0x24, core drives data_in = 0x12345678 at T+3 → rd_out at T+1; m1_ack at T+4 with m1_rdata 0x12345678.
- Both masters hold req for 4 writes each from reset → grant order m0, m1, m0, m1, m0, m1, m0, m1; 8 wr_out pulses, each separated by at least 2 idle cycles.
- rst asserted during WAIT of a read (RD_LAT = 3) → next cycle is IDLE with all outputs 0 and no ack; a subsequent simultaneous request is granted to m0.
- m0 raises req for 1 cycle while m1's read is in progress, then drops it → no m0 grant, no m0 ack, no extra strobe.
- PTP_ARB_LOCK_EN: m1 issues 2 reads (0x30, 0x34) with m1_lock high on the first and low on the second while m0 requests continuously → both m1 reads complete back-to-back, then m0 is granted.
